// File: rtl/leitor_display_pkg.sv
// Shared constants and types for the 7-segment scan readback logic.
package display_pkg;

  localparam int NUM_DIGITOS = 4;

  localparam logic [3:0] COD_BRANCO = 4'hF;
  localparam logic [3:0] COD_ERRO   = 4'hE;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0      = 7'h40;
  localparam logic [6:0] SEG_1      = 7'h79;
  localparam logic [6:0] SEG_2      = 7'h24;
  localparam logic [6:0] SEG_3      = 7'h30;
  localparam logic [6:0] SEG_4      = 7'h19;
  localparam logic [6:0] SEG_5      = 7'h12;
  localparam logic [6:0] SEG_6      = 7'h02;
  localparam logic [6:0] SEG_7      = 7'h78;
  localparam logic [6:0] SEG_8      = 7'h00;
  localparam logic [6:0] SEG_9      = 7'h10;
  localparam logic [6:0] SEG_BRANCO = 7'h7F;

  // Indexed by the decimal value the pattern represents
  localparam logic [6:0] SEG_DIGITO [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                                             SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};

  typedef enum logic {
    COLETA  = 1'b0,
    PUBLICA = 1'b1
  } estado_t;

  // True when exactly one active-low anode line is asserted
  function automatic logic um_ativo(input logic [NUM_DIGITOS-1:0] d);
    return ($countones(~d) == 1);
  endfunction

endpackage

// File: rtl/leitor_display_if.sv
// Scan bus plus decoded-frame outputs of the display readback monitor.
interface leitor_display_if;
  import display_pkg::*;

  logic [NUM_DIGITOS-1:0]   digitos;
  logic [7:0]               segmentos;
  logic [4*NUM_DIGITOS-1:0] valores;
  logic [NUM_DIGITOS-1:0]   pontos;
  logic                     quadro_valido;
  logic                     mudou;
  logic                     falha;

  // Side that drives the scan lines and observes the decoded frame
  modport master (
    output digitos, segmentos,
    input  valores, pontos, quadro_valido, mudou, falha
  );

  // The readback monitor itself
  modport slave (
    input  digitos, segmentos,
    output valores, pontos, quadro_valido, mudou, falha
  );

endinterface

// File: rtl/leitor_display_seg_para_codigo.sv
// Combinational active-low 7-segment pattern to 4-bit code decoder.
// Unknown patterns decode to COD_ERRO, all-off decodes to COD_BRANCO.
module seg_para_codigo
  import display_pkg::*;
(
  input  logic [6:0] padrao,
  output logic [3:0] codigo
);

  logic [9:0] acerto;

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_cmp
      assign acerto[gi] = (padrao == SEG_DIGITO[gi]);
    end
  endgenerate

  // Patterns are distinct, so at most one match bit is ever set
  always_comb begin
    codigo = COD_ERRO;
    if (padrao == SEG_BRANCO) begin
      codigo = COD_BRANCO;
    end
    for (int i = 0; i < 10; i++) begin
      if (acerto[i]) begin
        codigo = 4'(i);
      end
    end
  end

endmodule

// File: rtl/leitor_display.sv
// Readback monitor for the multiplexed 4-digit 7-segment bus: samples the
// scan lines, accepts each digit slot once it has been stable, decodes it and
// publishes a full frame once every digit has been seen.
module leitor_display
  import display_pkg::*;
#(
  parameter int ESTAVEL = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input logic             clock,
  input logic             reset,
  leitor_display_if.slave bus
);

  localparam int CW = $clog2(ESTAVEL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] EST_MAX = CW'(ESTAVEL);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  logic [NUM_DIGITOS-1:0]   dig_reg;
  logic [7:0]               seg_reg;
  logic [NUM_DIGITOS-1:0]   dig_prev_reg;
  logic [7:0]               seg_prev_reg;
  logic [CW-1:0]            cnt_reg, cnt_next;
  logic [TW-1:0]            tmo_reg;
  logic [NUM_DIGITOS-1:0]   vistos_reg, vistos_next;
  logic [3:0]               sombra_cod_reg [NUM_DIGITOS];
  logic [NUM_DIGITOS-1:0]   sombra_pt_reg;
  logic [4*NUM_DIGITOS-1:0] sombra_val;
  logic [4*NUM_DIGITOS-1:0] valores_reg;
  logic [NUM_DIGITOS-1:0]   pontos_reg;
  logic                     mudou_reg;
  estado_t                  estado_reg, estado_next;

  logic                     amostra_ok;
  logic                     igual;
  logic                     aceita;
  logic                     publica;
  logic [NUM_DIGITOS-1:0]   aceita_dig;
  logic [3:0]               cod_atual;

  // Input register: every decision below uses these registered pins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dig_reg <= '1;
      seg_reg <= '1;
    end else begin
      dig_reg <= bus.digitos;
      seg_reg <= bus.segmentos;
    end
  end

  seg_para_codigo u_decod (
    .padrao (seg_reg[6:0]),
    .codigo (cod_atual)
  );

  assign amostra_ok = um_ativo(dig_reg);
  assign igual      = (dig_reg == dig_prev_reg) && (seg_reg == seg_prev_reg);

  // Stability count: saturates, reloads to 1 on a change, clears on invalid samples
  always_comb begin
    cnt_next = '0;
    if (amostra_ok) begin
      if (igual) begin
        cnt_next = (cnt_reg == EST_MAX) ? EST_MAX : cnt_reg + 1'b1;
      end else begin
        cnt_next = CW'(1);
      end
    end
  end

  // Accept only on the transition into saturation so a held slot counts once
  assign aceita  = amostra_ok && (cnt_next == EST_MAX) && (cnt_reg != EST_MAX);
  assign publica = (estado_reg == COLETA) && (vistos_reg == '1);

  generate
    for (genvar gi = 0; gi < NUM_DIGITOS; gi++) begin : g_digito
      assign aceita_dig[gi]          = aceita && !dig_reg[gi];
      assign sombra_val[4*gi +: 4]   = sombra_cod_reg[gi];
    end
  endgenerate

  // Stability counter and last valid sample; invalid samples leave the sample alone
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg      <= '0;
      dig_prev_reg <= '1;
      seg_prev_reg <= '1;
    end else begin
      cnt_reg <= cnt_next;
      if (amostra_ok && !igual) begin
        dig_prev_reg <= dig_reg;
        seg_prev_reg <= seg_reg;
      end
    end
  end

  // Shadow registers: latest accepted code and dp per digit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITOS; i++) begin
        sombra_cod_reg[i] <= COD_BRANCO;
      end
      sombra_pt_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITOS; i++) begin
        if (aceita_dig[i]) begin
          sombra_cod_reg[i] <= cod_atual;
          sombra_pt_reg[i]  <= ~seg_reg[7];
        end
      end
    end
  end

  // Seen mask: a publish clears it, but a same-cycle acceptance starts the next frame
  always_comb begin
    vistos_next = publica ? '0 : vistos_reg;
    vistos_next = vistos_next | aceita_dig;
  end

  // Seen-mask register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vistos_reg <= '0;
    end else begin
      vistos_reg <= vistos_next;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg <= COLETA;
    end else begin
      estado_reg <= estado_next;
    end
  end

  // FSM next state: PUBLICA lasts exactly one cycle
  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      COLETA:  if (vistos_reg == '1) estado_next = PUBLICA;
      PUBLICA: estado_next = COLETA;
      default: estado_next = COLETA;
    endcase
  end

  // Frame registers loaded on the edge that enters PUBLICA
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valores_reg <= {NUM_DIGITOS{COD_BRANCO}};
      pontos_reg  <= '0;
      mudou_reg   <= 1'b0;
    end else begin
      mudou_reg <= 1'b0;
      if (publica) begin
        valores_reg <= sombra_val;
        pontos_reg  <= sombra_pt_reg;
        mudou_reg   <= ({sombra_val, sombra_pt_reg} != {valores_reg, pontos_reg});
      end
    end
  end

  // Timeout counter: restarts on every publish, saturates at the limit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_reg <= '0;
    end else if (publica) begin
      tmo_reg <= '0;
    end else if (tmo_reg != TMO_MAX) begin
      tmo_reg <= tmo_reg + 1'b1;
    end
  end

  // FSM/output decode; everything here comes straight from registers
  always_comb begin
    bus.valores       = valores_reg;
    bus.pontos        = pontos_reg;
    bus.mudou         = mudou_reg;
    bus.quadro_valido = (estado_reg == PUBLICA);
    bus.falha         = (tmo_reg == TMO_MAX);
  end

endmodule

// File: tb/tb_leitor_display.sv
// Directed bench for leitor_display (ESTAVEL=4, TIMEOUT=100).
module tb_leitor_display;

  logic clock = 1'b0;
  logic reset = 1'b1;

  leitor_display_if bus ();

  leitor_display #(
    .ESTAVEL (4),
    .TIMEOUT (100)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Anode selects (active low) and segment bytes {dp,g..a} (active low)
  localparam logic [3:0] D0 = 4'b1110, D1 = 4'b1101, D2 = 4'b1011, D3 = 4'b0111;
  localparam logic [3:0] DNONE = 4'b1111, DDUPLO = 4'b0011;
  localparam logic [7:0] S0 = 8'hC0, S0P = 8'h40, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0;
  localparam logic [7:0] S4 = 8'h99, S5 = 8'h92, S6 = 8'h82, S7 = 8'hF8, S8 = 8'h80;
  localparam logic [7:0] S9 = 8'h90, SBL = 8'hFF, SRUIM = 8'hF0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int qv_cnt = 0;
  int mu_cnt = 0;
  int pub_cyc = 0;
  logic falha_prev = 1'b0;
  logic falha_na_pub = 1'b0;
  logic falha_antes_pub = 1'b0;
  int q0, m0, c3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (bus.quadro_valido === 1'b1) begin
      qv_cnt++;
      if (bus.mudou === 1'b1) mu_cnt++;
      pub_cyc         = cyc;
      falha_na_pub    = bus.falha;
      falha_antes_pub = falha_prev;
    end
    falha_prev = bus.falha;
  endtask

  task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
    bus.digitos   = d;
    bus.segmentos = s;
    repeat (n) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valores"}, 32'(bus.valores), 32'hFFFF);
    chk({tag, "_pontos"},  32'(bus.pontos), 32'h0);
    chk({tag, "_qv"},      32'(bus.quadro_valido), 32'h0);
    chk({tag, "_mudou"},   32'(bus.mudou), 32'h0);
    chk({tag, "_falha"},   32'(bus.falha), 32'h0);
  endtask

  initial begin
    bus.digitos   = DNONE;
    bus.segmentos = SBL;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;

    // Basic frame "4321"
    q0 = qv_cnt; m0 = mu_cnt;
    hold(D0, S1, 8);
    hold(D1, S2, 8);
    hold(D2, S3, 8);
    c3 = cyc;
    hold(D3, S4, 8);
    hold(DNONE, SBL, 3);
    chk("basic_qv_count", 32'(qv_cnt - q0), 32'd1);
    chk("basic_latency", 32'(pub_cyc - c3), 32'd6);
    chk("basic_valores", 32'(bus.valores), 32'h4321);
    chk("basic_pontos", 32'(bus.pontos), 32'h0);
    chk("basic_mudou", 32'(mu_cnt - m0), 32'd1);
    $display("frame basic: valores=%h pontos=%b", bus.valores, bus.pontos);

    // Glitch: a 3-clock "8" on digit 2 must not be accepted
    q0 = qv_cnt; m0 = mu_cnt;
    hold(D0, S1, 8);
    hold(D1, S2, 8);
    hold(D2, S8, 3);
    hold(D2, S5, 8);
    hold(D3, S4, 8);
    hold(DNONE, SBL, 3);
    chk("glitch_qv_count", 32'(qv_cnt - q0), 32'd1);
    chk("glitch_valores", 32'(bus.valores), 32'h4521);
    chk("glitch_mudou", 32'(mu_cnt - m0), 32'd1);
    $display("frame glitch: valores=%h pontos=%b", bus.valores, bus.pontos);

    // Illegal anodes (two low) must not complete the frame; bad pattern -> E
    q0 = qv_cnt; m0 = mu_cnt;
    hold(D0, SRUIM, 8);
    hold(D1, S7, 8);
    hold(D2, S9, 8);
    hold(DDUPLO, S3, 10);
    chk("illegal_no_publish", 32'(qv_cnt - q0), 32'd0);
    hold(D3, S3, 8);
    hold(DNONE, SBL, 3);
    chk("illegal_qv_count", 32'(qv_cnt - q0), 32'd1);
    chk("illegal_valores", 32'(bus.valores), 32'h397E);
    chk("illegal_pontos", 32'(bus.pontos), 32'h0);
    $display("frame illegal: valores=%h pontos=%b", bus.valores, bus.pontos);

    // Same frame twice: mudou only on the first
    q0 = qv_cnt; m0 = mu_cnt;
    for (int r = 0; r < 2; r++) begin
      hold(D0, S0, 8);
      hold(D1, S0P, 8);
      hold(D2, S0, 8);
      hold(D3, S0, 8);
      hold(DNONE, SBL, 3);
      chk("repeat_mudou_running", 32'(mu_cnt - m0), 32'd1);
    end
    chk("repeat_qv_count", 32'(qv_cnt - q0), 32'd2);
    chk("repeat_valores", 32'(bus.valores), 32'h0000);
    chk("repeat_pontos", 32'(bus.pontos), 32'b0010);
    $display("frame repeat: valores=%h pontos=%b", bus.valores, bus.pontos);

    // Timeout: falha rises exactly 100 clocks after the last publish
    bus.digitos   = DNONE;
    bus.segmentos = SBL;
    repeat (pub_cyc + 99 - cyc) tick();
    chk("timeout_before", 32'(bus.falha), 32'h0);
    tick();
    chk("timeout_at", 32'(bus.falha), 32'h1);
    repeat (20) tick();
    chk("timeout_hold", 32'(bus.falha), 32'h1);
    q0 = qv_cnt; m0 = mu_cnt;
    hold(D0, S1, 8);
    hold(D1, S2, 8);
    hold(D2, S3, 8);
    hold(D3, S4, 8);
    hold(DNONE, SBL, 3);
    chk("recover_qv_count", 32'(qv_cnt - q0), 32'd1);
    chk("recover_falha_before", 32'(falha_antes_pub), 32'h1);
    chk("recover_falha_at_pub", 32'(falha_na_pub), 32'h0);
    chk("recover_valores", 32'(bus.valores), 32'h4321);
    chk("recover_mudou", 32'(mu_cnt - m0), 32'd1);
    $display("frame recover: valores=%h pontos=%b", bus.valores, bus.pontos);

    // Reset mid-frame discards captured digits 0 and 1
    hold(D0, S7, 8);
    hold(D1, S8, 8);
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    tick();
    tick();
    reset = 1'b0;
    q0 = qv_cnt; m0 = mu_cnt;
    hold(D0, S6, 8);
    hold(D1, S9, 8);
    chk("midreset_no_stale", 32'(qv_cnt - q0), 32'd0);
    hold(D2, S2, 8);
    hold(D3, S3, 8);
    hold(DNONE, SBL, 3);
    chk("midreset_qv_count", 32'(qv_cnt - q0), 32'd1);
    chk("midreset_valores", 32'(bus.valores), 32'h3296);
    chk("midreset_mudou", 32'(mu_cnt - m0), 32'd1);
    $display("frame midreset: valores=%h pontos=%b", bus.valores, bus.pontos);

    // First frame after reset equal to the reset values: no mudou
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q0 = qv_cnt; m0 = mu_cnt;
    hold(D0, SBL, 8);
    hold(D1, SBL, 8);
    hold(D2, SBL, 8);
    hold(D3, SBL, 8);
    hold(DNONE, SBL, 3);
    chk("blank_qv_count", 32'(qv_cnt - q0), 32'd1);
    chk("blank_valores", 32'(bus.valores), 32'hFFFF);
    chk("blank_no_mudou", 32'(mu_cnt - m0), 32'd0);
    $display("frame blank: valores=%h pontos=%b", bus.valores, bus.pontos);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
